// File: rtl/debounced_button_led_pio.sv
// Push-button PIO slave: per-button synchronizer and debouncer, edge capture with
// a maskable interrupt, and LED outputs with an optional shared blink phase.

module debounce_lane #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic stable
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             pressed;

    // Polarity is fixed before the first flop so the whole lane sees 1 = pressed.
    assign pressed = (ACTIVE_LOW != 0) ? ~pin : pin;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync1 <= pressed;
            sync2 <= sync1;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module debounced_button_led_pio #(
    parameter int          BTN_W           = 4,
    parameter int          LED_W           = 2,
    parameter int          DEBOUNCE_CYCLES = 50000,
    parameter int          BTN_ACTIVE_LOW  = 1,
    parameter int unsigned BLINK_RESET     = 12499999
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    input  logic [BTN_W-1:0] button_in,
    output logic [LED_W-1:0] led_out
);
    typedef struct packed {
        logic        wr;
        logic        rd;
        logic [2:0]  addr;
        logic [31:0] data;
    } bus_req_t;

    bus_req_t         req;
    logic [BTN_W-1:0] stable;
    logic [BTN_W-1:0] stable_d;
    logic [BTN_W-1:0] irq_mask;
    logic [BTN_W-1:0] edge_cap;
    logic [BTN_W-1:0] edge_set;
    logic [BTN_W-1:0] cap_clr;
    logic [BTN_W-1:0] rise;
    logic [BTN_W-1:0] fall;
    logic [LED_W-1:0] led_data;
    logic [LED_W-1:0] led_blink;
    logic [23:0]      blink_period;
    logic [23:0]      blink_cnt;
    logic             blink_phase;
    logic [1:0]       edge_mode;
    logic [31:0]      rd_mux;
    logic             wr_mask, wr_cap, wr_led, wr_blink, wr_period, wr_mode;
    logic             unused_data;

    assign req = '{wr: chipselect & write, rd: chipselect & read, addr: address, data: writedata};
    assign unused_data = ^req.data[31:24];

    for (genvar i = 0; i < BTN_W; i++) begin : g_lane
        debounce_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (BTN_ACTIVE_LOW)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .pin   (button_in[i]),
            .stable(stable[i])
        );
    end

    assign wr_mask   = req.wr && (req.addr == 3'd1);
    assign wr_cap    = req.wr && (req.addr == 3'd2);
    assign wr_led    = req.wr && (req.addr == 3'd3);
    assign wr_blink  = req.wr && (req.addr == 3'd4);
    assign wr_period = req.wr && (req.addr == 3'd5);
    assign wr_mode   = req.wr && (req.addr == 3'd6);

    assign rise    = stable & ~stable_d;
    assign fall    = ~stable & stable_d;
    assign cap_clr = wr_cap ? req.data[BTN_W-1:0] : '0;

    always_comb begin
        edge_set = rise;
        if (edge_mode[1])      edge_set = rise | fall;
        else if (edge_mode[0]) edge_set = fall;
    end

    always_comb begin
        rd_mux = '0;
        case (req.addr)
            3'd0:    rd_mux[BTN_W-1:0] = stable;
            3'd1:    rd_mux[BTN_W-1:0] = irq_mask;
            3'd2:    rd_mux[BTN_W-1:0] = edge_cap;
            3'd3:    rd_mux[LED_W-1:0] = led_data;
            3'd4:    rd_mux[LED_W-1:0] = led_blink;
            3'd5:    rd_mux[23:0]      = blink_period;
            3'd6:    rd_mux[1:0]       = edge_mode;
            default: rd_mux            = '0;
        endcase
    end

    // Purely register-driven so bus activity cannot glitch the interrupt line.
    assign irq = |(edge_cap & irq_mask);

    always_ff @(posedge clk) begin
        if (reset) begin
            stable_d  <= '0;
            irq_mask  <= '0;
            edge_cap  <= '0;
            led_data  <= '0;
            led_blink <= '0;
            edge_mode <= '0;
            readdata  <= '0;
            led_out   <= '0;
        end else begin
            stable_d <= stable;
            // A capture arriving with a W1C on the same bit wins.
            edge_cap <= (edge_cap & ~cap_clr) | edge_set;
            readdata <= req.rd ? rd_mux : '0;
            led_out  <= led_data & (~led_blink | {LED_W{blink_phase}});
            if (wr_mask)  irq_mask  <= req.data[BTN_W-1:0];
            if (wr_led)   led_data  <= req.data[LED_W-1:0];
            if (wr_blink) led_blink <= req.data[LED_W-1:0];
            if (wr_mode)  edge_mode <= req.data[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_period <= 24'(BLINK_RESET);
            blink_cnt    <= '0;
            blink_phase  <= 1'b1;
        end else if (wr_period) begin
            blink_period <= req.data[23:0];
            blink_cnt    <= '0;
        end else if (blink_cnt == blink_period) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 24'd1;
        end
    end
endmodule

// File: tb/tb_debounced_button_led_pio.sv
// Randomized and scenario bench for debounced_button_led_pio, checked against a
// cycle-level behavioural model of the register map and debounce rules.

module tb_debounced_button_led_pio;
    localparam int BTN_W = 4;
    localparam int LED_W = 2;
    localparam int DEB   = 8;
    localparam int BLINK_DEF = 12499999;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [2:0]       address = '0;
    logic             chipselect = 1'b0;
    logic             read = 1'b0;
    logic             write = 1'b0;
    logic [31:0]      writedata = '0;
    logic [31:0]      readdata;
    logic             irq;
    logic [BTN_W-1:0] button_in = '1;
    logic [LED_W-1:0] led_out;

    always #5 clk = ~clk;

    debounced_button_led_pio #(
        .BTN_W(BTN_W), .LED_W(LED_W), .DEBOUNCE_CYCLES(DEB), .BTN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .read(read), .write(write), .writedata(writedata), .readdata(readdata),
        .irq(irq), .button_in(button_in), .led_out(led_out)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model state: what the register map should hold after each clock edge.
    logic [BTN_W-1:0] hist[$];
    int               m_run[BTN_W];
    logic [BTN_W-1:0] m_stable, m_rise, m_fall, m_mask, m_cap;
    logic [LED_W-1:0] m_led_data, m_led_blink, m_led;
    logic [1:0]       m_mode;
    int               m_period, m_ticks;
    logic             m_phase;
    logic [31:0]      m_rdata;

    task automatic model_step();
        logic [BTN_W-1:0] s, setv, clr, ncap;
        logic [LED_W-1:0] nled;
        logic [31:0]      nrd;
        logic             wr, rd;
        if (reset) begin
            hist.delete();
            hist.push_back('0);
            hist.push_back('0);
            foreach (m_run[i]) m_run[i] = 0;
            m_stable = '0; m_rise = '0; m_fall = '0; m_mask = '0; m_cap = '0;
            m_led_data = '0; m_led_blink = '0; m_led = '0; m_mode = '0;
            m_period = BLINK_DEF; m_ticks = 0; m_phase = 1'b1; m_rdata = '0;
            return;
        end
        wr = chipselect & write;
        rd = chipselect & read;
        nrd = 0;
        if (rd) begin
            case (address)
                3'd0: nrd = 32'(m_stable);
                3'd1: nrd = 32'(m_mask);
                3'd2: nrd = 32'(m_cap);
                3'd3: nrd = 32'(m_led_data);
                3'd4: nrd = 32'(m_led_blink);
                3'd5: nrd = m_period;
                3'd6: nrd = 32'(m_mode);
                default: nrd = 0;
            endcase
        end
        setv = m_mode[1] ? (m_rise | m_fall) : (m_mode[0] ? m_fall : m_rise);
        clr  = (wr && address == 3'd2) ? writedata[BTN_W-1:0] : '0;
        ncap = (m_cap & ~clr) | setv;
        nled = m_led_data & ~(m_led_blink & {LED_W{~m_phase}});
        // Blink phase flips once every period+1 edges; a period write restarts the count.
        if (wr && address == 3'd5) m_ticks = 0;
        else if (m_ticks == m_period) begin m_ticks = 0; m_phase = ~m_phase; end
        else m_ticks++;
        // Debouncer sees pins two edges late; accepts a level after DEB differing samples in a row.
        s = hist.pop_front();
        hist.push_back(~button_in);
        m_rise = '0; m_fall = '0;
        for (int i = 0; i < BTN_W; i++) begin
            if (s[i] != m_stable[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_stable[i] = s[i];
                    m_run[i] = 0;
                    if (s[i]) m_rise[i] = 1'b1; else m_fall[i] = 1'b1;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        if (wr) begin
            case (address)
                3'd1: m_mask = writedata[BTN_W-1:0];
                3'd3: m_led_data = writedata[LED_W-1:0];
                3'd4: m_led_blink = writedata[LED_W-1:0];
                3'd5: m_period = int'(writedata[23:0]);
                3'd6: m_mode = writedata[1:0];
                default: ;
            endcase
        end
        m_cap = ncap;
        m_led = nled;
        m_rdata = nrd;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("readdata", readdata, m_rdata);
        chk("irq", 32'(irq), 32'(|(m_cap & m_mask)));
        chk("led_out", 32'(led_out), 32'(m_led));
    endtask

    task automatic wait_n(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write = 1'b0; writedata = '0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] r);
        chipselect = 1'b1; read = 1'b1; address = a;
        tick();
        r = readdata;
        chipselect = 1'b0; read = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        int          t, ones;
        logic [LED_W-1:0] prev;

        @(negedge clk);
        wait_n(2);
        chk("rst_readdata", readdata, 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_led", 32'(led_out), 0);
        reset = 1'b0;
        bus_read(3'd5, r);
        chk("rst_period", r, BLINK_DEF);

        // Press and hold button 0: accepted on the 10th edge, captured on the 11th.
        button_in[0] = 1'b0;
        wait_n(9);
        bus_read(3'd0, r);
        chk("s1_data_early", r, 0);
        bus_read(3'd0, r);
        chk("s1_data", r, 1);
        chk("s1_irq_masked", 32'(irq), 0);
        bus_read(3'd2, r);
        chk("s1_cap", r, 1);
        bus_write(3'd1, 1);
        chk("s1_irq_unmasked", 32'(irq), 1);
        button_in[0] = 1'b1;
        wait_n(12);
        bus_read(3'd2, r);
        chk("s1_cap_after_release", r, 1);
        bus_write(3'd2, 32'hF);
        chk("s1_irq_cleared", 32'(irq), 0);
        bus_write(3'd1, 32'hF);

        // Short bounces on button 1 never reach the debounce threshold.
        for (int k = 0; k < 3; k++) begin
            button_in[1] = 1'b0; wait_n(5);
            button_in[1] = 1'b1; wait_n(5);
        end
        wait_n(12);
        bus_read(3'd0, r);
        chk("s2_data", r, 0);
        bus_read(3'd2, r);
        chk("s2_cap", r, 0);
        chk("s2_irq", 32'(irq), 0);

        // Both-edge mode on button 2, then W1C.
        bus_write(3'd6, 2);
        button_in[2] = 1'b0; wait_n(12);
        bus_read(3'd2, r);
        chk("s3_cap_press", r, 4);
        chk("s3_irq", 32'(irq), 1);
        button_in[2] = 1'b1; wait_n(12);
        bus_read(3'd2, r);
        chk("s3_cap_release", r, 4);
        bus_write(3'd2, 4);
        chk("s3_irq_fall", 32'(irq), 0);
        bus_read(3'd2, r);
        chk("s3_cap_cleared", r, 0);

        // W1C landing on the capture edge of button 3 loses to the set.
        button_in[3] = 1'b0;
        wait_n(10);
        bus_write(3'd2, 8);
        bus_read(3'd2, r);
        chk("s4_set_wins", r, 8);
        bus_write(3'd2, 8);
        bus_read(3'd2, r);
        chk("s4_w1c", r, 0);
        button_in[3] = 1'b1; wait_n(12);
        bus_write(3'd2, 7);
        bus_read(3'd2, r);
        chk("s4_w1c_other_bits", r, 8);
        bus_write(3'd2, 8);

        // LED blink: period 3 gives a flip every 4 cycles, period 0 every cycle.
        bus_write(3'd3, 3);
        bus_write(3'd4, 1);
        bus_write(3'd5, 3);
        tick();
        prev = led_out; t = 0; ones = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (led_out[0] != prev[0]) t++;
            if (led_out[1]) ones++;
            prev = led_out;
        end
        chk("s5_toggles_p3", t, 4);
        chk("s5_led1_steady", ones, 16);
        bus_write(3'd5, 0);
        tick();
        prev = led_out; t = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (led_out[0] != prev[0]) t++;
            prev = led_out;
        end
        chk("s5_toggles_p0", t, 8);

        // Reserved address, idle DATA, then reset during a debounce and a read.
        bus_read(3'd7, r);
        chk("s6_reserved", r, 0);
        bus_read(3'd0, r);
        chk("s6_data_idle", r, 0);
        button_in[0] = 1'b0;
        wait_n(5);
        reset = 1'b1; chipselect = 1'b1; read = 1'b1; address = 3'd5;
        tick();
        chipselect = 1'b0; read = 1'b0;
        tick();
        chk("s6_rst_readdata", readdata, 0);
        chk("s6_rst_irq", 32'(irq), 0);
        chk("s6_rst_led", 32'(led_out), 0);
        reset = 1'b0;
        bus_read(3'd5, r);
        chk("s6_period", r, BLINK_DEF);
        wait_n(8);
        bus_read(3'd0, r);
        chk("s6_full_debounce_early", r, 0);
        bus_read(3'd0, r);
        chk("s6_full_debounce", r, 1);
        button_in[0] = 1'b1;
        wait_n(12);

        // Random traffic against the model.
        for (int k = 0; k < 2000; k++) begin
            int op;
            if ($urandom_range(0, 11) == 0) begin
                int b = $urandom_range(0, BTN_W - 1);
                button_in[b] = ~button_in[b];
            end
            op = $urandom_range(0, 5);
            chipselect = ($urandom_range(0, 7) != 0);
            read = (op == 1 || op == 2);
            write = (op == 3 || op == 4);
            address = 3'($urandom_range(0, 7));
            writedata = (address == 3'd5) ? 32'($urandom_range(0, 6)) : $urandom;
            reset = ($urandom_range(0, 499) == 0);
            tick();
        end
        chipselect = 1'b0; read = 1'b0; write = 1'b0; reset = 1'b0;
        wait_n(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
